ex_if_redirect: RTL and testbench
=================================

# ex_if_redirect

Control-flow redirect unit on the backward path from the execute stage to instruction fetch. Accepts a taken branch/jump resolved in EX, registers the target PC, drives it to IF with a valid strobe, and asserts flush to the IF/ID and ID/EX pipeline registers long enough to squash wrong-path instructions. Honours the memory stall `stl_mm` exactly as the forward pipeline registers do: nothing advances while it is high.

## Interface

Parameters:
- `FLUSH_CYC`, default 2: cycles of flush held after a redirect (range 1–7).

Ports:
- `clk`  in  1: single clock, all state on rising edge.
- `rst`  in  1: reset; synchronous, active-high.
- `ex_br`  in  1: EX resolved a taken branch/jump this cycle.
- `ex_tgt`  in  32: target address from EX (unaligned bit 0 permitted).
- `stl_mm`  in  1: memory stall; freezes all state except capture into PEND.
- `if_pc`  out  32: redirect target for IF, bit 0 forced to 0.
- `if_pce`  out  1: `if_pc` valid; IF loads `if_pc` on any cycle with `if_pce=1` and `stl_mm=0`.
- `flush_id`  out  1: clear IF/ID register to a bubble.
- `flush_ex`  out  1: clear ID/EX register to a bubble (`ex_we=0`).

## Operation

- States: IDLE, PEND, FLUSH; counter `cnt` 3 bits.
- IDLE:
  - `ex_br=1`, `stl_mm=0` → latch `{ex_tgt[31:1],1'b0}` into `if_pc`, `cnt<=FLUSH_CYC-1`, `if_pce<=1`, go FLUSH.
  - `ex_br=1`, `stl_mm=1` → latch target, go PEND; `if_pce` stays 0.
  - Otherwise stay.
- PEND: hold target, ignore `ex_br`. On the first cycle with `stl_mm=0`, load `cnt`, set `if_pce`, and go FLUSH.
- FLUSH:
  - `flush_id=flush_ex=1` throughout.
  - `ex_br` is ignored, because it is wrong-path.
  - `if_pce` stays 1 until a cycle in FLUSH with `stl_mm=0`, then clears on the next edge.
  - When `stl_mm=0`: if `cnt==0`, go IDLE and drop both flushes on the next edge; else `cnt<=cnt-1`.
  - When `stl_mm=1`: `cnt` and `if_pce` are frozen.
- Reset (any state, any cycle): state IDLE, `cnt=0`, `if_pc=0`, `if_pce=0`, `flush_id=0`, `flush_ex=0`. A pending or in-flight redirect is discarded.
- Simultaneous `rst` and `ex_br`: reset wins.
- A second `ex_br` while in PEND or FLUSH is dropped; the older branch always wins.

## Timing

- All outputs are registered.
- Latency from `ex_br` sampled (no stall) to `if_pce=1`/flush visible: 1 cycle.
- Flush duration with no stall: exactly `FLUSH_CYC` cycles. Each stalled cycle extends it by 1.
- From PEND, the redirect appears 1 cycle after `stl_mm` falls.
- Back-to-back: a new `ex_br` is accepted in the first IDLE cycle after FLUSH exits.

## Configuration

- `REDIRECT_CNT_EN` defined:
  - Adds port `redir_cnt  out  32`, reset 0.
  - Increments by 1 on every entry to FLUSH and wraps at 2^32.
- Undefined: port and logic are absent; all other behaviour is identical.

## Structure

- Shared package `rv_pkg`:
  - State encoding constants `RD_IDLE=2'd0`, `RD_PEND=2'd1`, `RD_FLUSH=2'd2`.
  - `XLEN=32`.
- One natural sub-module: `redirect_ctr`, the down-counter with load/hold/done (`ld`, `en`, `val`, `zero`), instantiated for `cnt`.

## Test plan

- Reset: hold `rst=1` for 2 cycles with `ex_br=1` → all outputs 0 and state IDLE on the cycle after release.
- Basic redirect:
  - Stimulus: `ex_br=1`, `ex_tgt=0x0000_1235`, `stl_mm=0`, `FLUSH_CYC=2`.
  - Next cycle: `if_pc=0x0000_1234`, `if_pce=1`, both flushes 1.
  - `if_pce` then falls; flushes fall after 2 cycles.
- Stall on capture: `ex_br=1` with `stl_mm=1` for 3 cycles → outputs stay 0. `stl_mm` falls → `if_pce=1` with the latched target 1 cycle later.
- Stall mid-flush: `stl_mm=1` for 2 cycles starting in the first FLUSH cycle → `if_pce` and flushes held, giving a total flush of 4 cycles.
- Ignored branch: second `ex_br` with `ex_tgt=0x2000` during FLUSH → `if_pc` stays `0x1234`. A subsequent `ex_br` after IDLE is accepted.
- Reset mid-FLUSH: `rst=1` in the second FLUSH cycle → all outputs 0 next cycle. With `REDIRECT_CNT_EN`, `redir_cnt` returns to 0; with two prior redirects it read 2.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared definitions for the EX->IF redirect path: datapath width, redirect
// FSM state encoding and PC alignment helper.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_PEND  = 2'd1,
    RD_FLUSH = 2'd2
  } rd_state_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return {a[XLEN-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/redirect_ctr.sv
// 3-bit down-counter with synchronous load and hold; zero flags terminal count.
module redirect_ctr (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic       en,
  input  logic [2:0] val,
  output logic [2:0] cnt,
  output logic       zero
);

  logic [2:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)     r_cnt <= '0;
    else if (ld) r_cnt <= val;
    else if (en) r_cnt <= r_cnt - 3'd1;
  end

  assign cnt  = r_cnt;
  assign zero = (r_cnt == 3'd0);

endmodule

// File: rtl/ex_if_redirect.sv
// EX->IF control-flow redirect: registers the taken target, strobes it to IF
// and holds flush for FLUSH_CYC unstalled cycles. Optional: REDIRECT_CNT_EN.
module ex_if_redirect
  import rv_pkg::*;
#(
  parameter int unsigned FLUSH_CYC = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_br,
  input  logic [XLEN-1:0] ex_tgt,
  input  logic            stl_mm,
  output logic [XLEN-1:0] if_pc,
  output logic            if_pce,
  output logic            flush_id,
  output logic            flush_ex
`ifdef REDIRECT_CNT_EN
  ,
  output logic [31:0]     redir_cnt
`endif
);

  rd_state_t       r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_pce;
  logic            r_flush;
  logic [2:0]      w_cnt;
  logic            w_zero;
  logic            w_enter;
  logic            w_dec;

  // FLUSH is entered from IDLE (unstalled branch) or from PEND once the stall lifts
  assign w_enter = !stl_mm && (((r_state == RD_IDLE) && ex_br) || (r_state == RD_PEND));
  assign w_dec   = !stl_mm && (r_state == RD_FLUSH) && !w_zero;

  redirect_ctr u_ctr (
    .clk  (clk),
    .rst  (rst),
    .ld   (w_enter),
    .en   (w_dec),
    .val  (3'(FLUSH_CYC - 1)),
    .cnt  (w_cnt),
    .zero (w_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RD_IDLE;
      r_pc    <= '0;
      r_pce   <= 1'b0;
      r_flush <= 1'b0;
    end else begin
      case (r_state)
        RD_IDLE: begin
          if (ex_br) begin
            r_pc <= align_pc(ex_tgt);
            if (stl_mm) begin
              r_state <= RD_PEND;
            end else begin
              r_state <= RD_FLUSH;
              r_pce   <= 1'b1;
              r_flush <= 1'b1;
            end
          end
        end
        RD_PEND: begin
          if (!stl_mm) begin
            r_state <= RD_FLUSH;
            r_pce   <= 1'b1;
            r_flush <= 1'b1;
          end
        end
        RD_FLUSH: begin
          if (!stl_mm) begin
            r_pce <= 1'b0;
            if (w_zero) begin
              r_state <= RD_IDLE;
              r_flush <= 1'b0;
            end
          end
        end
        default: r_state <= RD_IDLE;
      endcase
    end
  end

  assign if_pc    = r_pc;
  assign if_pce   = r_pce;
  assign flush_id = r_flush;
  assign flush_ex = r_flush;

`ifdef REDIRECT_CNT_EN
  logic [31:0] r_redir_cnt;

  always_ff @(posedge clk) begin
    if (rst)          r_redir_cnt <= '0;
    else if (w_enter) r_redir_cnt <= r_redir_cnt + 32'd1;
  end

  assign redir_cnt = r_redir_cnt;
`endif

endmodule

// File: tb/tb_ex_if_redirect.sv
// Scoreboard bench for ex_if_redirect (FLUSH_CYC=2): the driver queues the
// expected post-edge outputs per cycle, a monitor pops and compares them.
module tb_ex_if_redirect;
  import rv_pkg::*;

  logic            clk;
  logic            rst;
  logic            ex_br;
  logic [XLEN-1:0] ex_tgt;
  logic            stl_mm;
  logic [XLEN-1:0] if_pc;
  logic            if_pce;
  logic            flush_id;
  logic            flush_ex;
`ifdef REDIRECT_CNT_EN
  logic [31:0]     redir_cnt;
`endif

  ex_if_redirect #(.FLUSH_CYC(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .ex_br    (ex_br),
    .ex_tgt   (ex_tgt),
    .stl_mm   (stl_mm),
    .if_pc    (if_pc),
    .if_pce   (if_pce),
    .flush_id (flush_id),
    .flush_ex (flush_ex)
`ifdef REDIRECT_CNT_EN
    ,
    .redir_cnt(redir_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        pce;
    logic        fl;
    logic [31:0] pc;
    bit          chk_pc;
    logic [31:0] rc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   drv_done = 1'b0;

  task automatic check(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s.%s: got 0x%08h, expected 0x%08h at %0t", nm, fld, act, req, $time);
    end
  endtask

  // Drive inputs for one cycle and queue the outputs expected after the next edge.
  task automatic step(input logic r, input logic br, input logic [31:0] tgt, input logic stl,
                      input logic e_pce, input logic e_fl, input logic [31:0] e_pc,
                      input bit chk_pc, input logic [31:0] e_rc, input string nm);
    exp_t e;
    rst = r; ex_br = br; ex_tgt = tgt; stl_mm = stl;
    e.nm = nm; e.pce = e_pce; e.fl = e_fl; e.pc = e_pc; e.chk_pc = chk_pc; e.rc = e_rc;
    q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: outputs sampled 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check(e.nm, "if_pce", {31'd0, if_pce}, {31'd0, e.pce});
        check(e.nm, "flush_id", {31'd0, flush_id}, {31'd0, e.fl});
        check(e.nm, "flush_ex", {31'd0, flush_ex}, {31'd0, e.fl});
        if (e.chk_pc) check(e.nm, "if_pc", if_pc, e.pc);
`ifdef REDIRECT_CNT_EN
        check(e.nm, "redir_cnt", redir_cnt, e.rc);
`endif
      end
    end
  end

  initial begin
    rst = 1'b1; ex_br = 1'b0; ex_tgt = '0; stl_mm = 1'b0;
    @(negedge clk);
    // reset held with a branch present
    step(1, 1, 32'h5555, 0,  0, 0, 32'h0, 1, 0, "rst0");
    step(1, 1, 32'h5555, 0,  0, 0, 32'h0, 1, 0, "rst1");
    step(0, 0, 32'h0,    0,  0, 0, 32'h0, 1, 0, "rst_rel");
    // basic redirect, FLUSH_CYC=2
    step(0, 1, 32'h1235, 0,  1, 1, 32'h1234, 1, 1, "basic_e1");
    step(0, 0, 32'h0,    0,  0, 1, 32'h1234, 1, 1, "basic_e2");
    step(0, 0, 32'h0,    0,  0, 0, 32'h1234, 1, 1, "basic_e3");
    // stall at capture; later branches in PEND are ignored
    step(0, 1, 32'h4001, 1,  0, 0, 32'h0, 0, 1, "pend1");
    step(0, 1, 32'h9999, 1,  0, 0, 32'h0, 0, 1, "pend2");
    step(0, 1, 32'h9999, 1,  0, 0, 32'h0, 0, 1, "pend3");
    step(0, 0, 32'h0,    0,  1, 1, 32'h4000, 1, 2, "pend_rel");
    step(0, 0, 32'h0,    0,  0, 1, 32'h4000, 1, 2, "pend_f2");
    step(0, 0, 32'h0,    0,  0, 0, 32'h4000, 1, 2, "pend_exit");
    // stall mid-flush stretches flush to 4 cycles
    step(0, 1, 32'h1234, 0,  1, 1, 32'h1234, 1, 3, "mid_f1");
    step(0, 0, 32'h0,    1,  1, 1, 32'h1234, 1, 3, "mid_st1");
    step(0, 0, 32'h0,    1,  1, 1, 32'h1234, 1, 3, "mid_st2");
    step(0, 0, 32'h0,    0,  0, 1, 32'h1234, 1, 3, "mid_f4");
    step(0, 0, 32'h0,    0,  0, 0, 32'h1234, 1, 3, "mid_exit");
    // branches during FLUSH dropped; accepted in first IDLE cycle
    step(0, 1, 32'h1235, 0,  1, 1, 32'h1234, 1, 4, "ign_f1");
    step(0, 1, 32'h2000, 0,  0, 1, 32'h1234, 1, 4, "ign_f2");
    step(0, 1, 32'h2000, 0,  0, 0, 32'h1234, 1, 4, "ign_exit");
    step(0, 1, 32'h2000, 0,  1, 1, 32'h2000, 1, 5, "b2b_f1");
    step(0, 0, 32'h0,    0,  0, 1, 32'h2000, 1, 5, "b2b_f2");
    step(0, 0, 32'h0,    0,  0, 0, 32'h2000, 1, 5, "b2b_exit");
    // reset in the second FLUSH cycle
    step(0, 1, 32'hABCD, 0,  1, 1, 32'hABCC, 1, 6, "rstf_f1");
    step(0, 0, 32'h0,    0,  0, 1, 32'hABCC, 1, 6, "rstf_f2");
    step(1, 1, 32'h7777, 0,  0, 0, 32'h0, 1, 0, "rstf_rst");
    step(0, 0, 32'h0,    0,  0, 0, 32'h0, 1, 0, "rstf_idle");
    // reset discards a pending redirect
    step(0, 1, 32'h0009, 1,  0, 0, 32'h0, 0, 0, "rstp_pend");
    step(1, 0, 32'h0,    0,  0, 0, 32'h0, 1, 0, "rstp_rst");
    step(0, 0, 32'h0,    0,  0, 0, 32'h0, 1, 0, "rstp_idle");
    step(0, 0, 32'h0,    0,  0, 0, 32'h0, 1, 0, "rstp_idle2");
    drv_done = 1'b1;
  end

  initial begin
    fork
      begin
        wait (drv_done);
        @(posedge clk);
        #2;
        if (q.size() != 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL drain: got %0d entries left, expected 0", q.size());
        end
      end
      begin
        #20000;
        n_cmp++;
        n_bad++;
        $display("FAIL timeout: got no completion, expected completion within 20000 time units");
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
